// File: rtl/prescaled_counter_if.sv
// Control/status bundle for prescaled_counter.
// The master side (system or bench) drives the controls and observes
// the count; the slave side is the counter itself.
interface prescaled_counter_if #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 10
);
  logic             EN;
  logic             DIR;
  logic             SAT;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] CNT;
  logic             TC;
  logic [OUT_W-1:0] LED;

  modport master (
    output EN, DIR, SAT, LOAD, LOAD_VAL,
    input  CNT, TC, LED
  );

  modport slave (
    input  EN, DIR, SAT, LOAD, LOAD_VAL,
    output CNT, TC, LED
  );
endinterface

// File: rtl/prescaled_counter.sv
// Prescaled up/down counter with programmable upper limit, wrap or
// saturate behaviour, synchronous load and a one-cycle terminal-count
// pulse aligned with the count value it reports.
// Optional build macro PRESCALED_COUNTER_GRAY_EN: LED shows the Gray code
// of the upper CNT field instead of plain binary. CNT/TC are unaffected.
module prescaled_counter #(
  parameter int              WIDTH    = 32,
  parameter int              OUT_W    = 10,
  parameter int              PRESCALE = 1,
  parameter longint unsigned TOP      = (64'd1 << WIDTH) - 64'd1
) (
  input  logic               CLK,
  input  logic               RST_X,
  prescaled_counter_if.slave bus
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] TOP_W    = TOP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             tick;
  logic [OUT_W-1:0] led_field;

  assign tick = bus.EN && (pre_q == PRE_LAST);

  // Next-state: load beats tick; a tick coincident with a load is dropped.
  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    if (bus.LOAD) begin
      cnt_d = (bus.LOAD_VAL > TOP_W) ? TOP_W : bus.LOAD_VAL;
      pre_d = '0;
    end else if (bus.EN) begin
      pre_d = tick ? '0 : pre_q + PRE_ONE;
      if (tick) begin
        if (bus.DIR) begin
          if (cnt_q < TOP_W) begin
            cnt_d = cnt_q + ONE_W;
            tc_d  = bus.SAT && ((cnt_q + ONE_W) == TOP_W);
          end else if (!bus.SAT) begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end
        end else begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE_W;
            tc_d  = bus.SAT && (cnt_q == ONE_W);
          end else if (!bus.SAT) begin
            cnt_d = TOP_W;
            tc_d  = 1'b1;
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      cnt_q <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
    end
  end

  assign led_field = cnt_q[WIDTH-1 -: OUT_W];

  // LED display of the upper count field, no added latency.
  always_comb begin
`ifdef PRESCALED_COUNTER_GRAY_EN
    bus.LED = led_field ^ (led_field >> 1);
`else
    bus.LED = led_field;
`endif
  end

  assign bus.CNT = cnt_q;
  assign bus.TC  = tc_q;

endmodule
